// File: rtl/hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_stall_ctrl
//  Description : Pipeline hazard sequencer for a 5-stage MIPS core. Sits
//                beside ID and owns the PC, IF/ID and ID/EX enables. Keeps a
//                one-entry scoreboard of the instruction in EX. It inserts
//                load-use stalls and multi-cycle multiply stalls, and flushes
//                on a taken branch. ALU-result hazards are forwarded and
//                never stall here.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    MUL_LAT         cycles a multiply occupies EX (>=1, 1 = no extra stall)
//    CNT_W           width of the saturating stall-cycle counter
//  Ports
//    Clk, Rst        clock (rising edge), async active-high reset
//    Valid_ID        ID holds a real instruction
//    rs_ID, rt_ID    ID source registers
//    UsesRs_ID/Rt_ID ID instruction reads rs / rt
//    RegWrite_ID     ID instruction writes WriteReg_ID
//    WriteReg_ID     ID destination register (after RegDst mux)
//    MemRead_ID      ID instruction is a load
//    IsMul_ID        ID instruction is a multiply
//    BranchTaken_EX  branch in EX resolved taken this cycle
//    PCWrite_out     PC may update
//    IFIDWrite_out   IF/ID may load
//    IFIDFlush_out   IF/ID loads a NOP
//    IDEXBubble_out  ID/EX loads a control-zero bubble
//    MulBusy_out     multiply occupying EX beyond its first cycle
//    StallCycles_out saturating count of stall cycles
// ============================================================================
module hazard_stall_ctrl #(
    parameter int MUL_LAT = 4,
    parameter int CNT_W   = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Valid_ID,
    input  logic [4:0]       rs_ID,
    input  logic [4:0]       rt_ID,
    input  logic             UsesRs_ID,
    input  logic             UsesRt_ID,
    input  logic             RegWrite_ID,
    input  logic [4:0]       WriteReg_ID,
    input  logic             MemRead_ID,
    input  logic             IsMul_ID,
    input  logic             BranchTaken_EX,
    output logic             PCWrite_out,
    output logic             IFIDWrite_out,
    output logic             IFIDFlush_out,
    output logic             IDEXBubble_out,
    output logic             MulBusy_out,
    output logic [CNT_W-1:0] StallCycles_out
);

    localparam int              MC_W       = $clog2(MUL_LAT + 1);
    localparam logic [MC_W-1:0] MUL_RELOAD = MC_W'(MUL_LAT - 1);

    // EX scoreboard, multiply occupancy and performance counter
    logic             ex_v_q,    ex_v_d;
    logic             ex_load_q, ex_load_d;
    logic [4:0]       ex_dst_q,  ex_dst_d;
    logic [MC_W-1:0]  mul_cnt_q, mul_cnt_d;
    logic [CNT_W-1:0] stall_q,   stall_d;

    logic mul_busy;
    logic load_use;
    logic advance;
    logic stall_cycle;

    assign mul_busy = (mul_cnt_q != '0);

    // $0 is hard-wired zero, so a load targeting it can never feed a consumer
    assign load_use = ex_v_q & ex_load_q & (ex_dst_q != 5'd0) & Valid_ID &
                      ((UsesRs_ID & (rs_ID == ex_dst_q)) |
                       (UsesRt_ID & (rt_ID == ex_dst_q)));

    // A multiply in flight freezes the front end and masks the branch; a taken
    // branch kills the ID instruction, so it beats any load-use hazard.
    always_comb begin
        PCWrite_out    = 1'b1;
        IFIDWrite_out  = 1'b1;
        IFIDFlush_out  = 1'b0;
        IDEXBubble_out = 1'b0;
        if (mul_busy) begin
            PCWrite_out   = 1'b0;
            IFIDWrite_out = 1'b0;
        end else if (BranchTaken_EX) begin
            IFIDFlush_out  = 1'b1;
            IDEXBubble_out = 1'b1;
        end else if (load_use) begin
            PCWrite_out    = 1'b0;
            IFIDWrite_out  = 1'b0;
            IDEXBubble_out = 1'b1;
        end
    end

    assign MulBusy_out     = mul_busy;
    assign StallCycles_out = stall_q;

    assign advance     = Valid_ID & ~mul_busy & ~BranchTaken_EX & ~load_use;
    assign stall_cycle = mul_busy | (~BranchTaken_EX & load_use);

    always_comb begin
        ex_v_d    = ex_v_q;
        ex_load_d = ex_load_q;
        ex_dst_d  = ex_dst_q;
        mul_cnt_d = mul_cnt_q;
        stall_d   = stall_q;

        if (mul_busy) begin
            // EX and ID/EX hold; only the occupancy count moves
            mul_cnt_d = mul_cnt_q - MC_W'(1);
        end else if (advance) begin
            ex_v_d    = 1'b1;
            ex_load_d = MemRead_ID & RegWrite_ID;
            ex_dst_d  = WriteReg_ID;
            if (IsMul_ID) begin
                mul_cnt_d = MUL_RELOAD;
            end
        end else begin
            // bubble, flush or empty ID slot enters EX
            ex_v_d = 1'b0;
        end

        if (stall_cycle && (stall_q != '1)) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            ex_v_q    <= 1'b0;
            ex_load_q <= 1'b0;
            ex_dst_q  <= 5'd0;
            mul_cnt_q <= '0;
            stall_q   <= '0;
        end else begin
            ex_v_q    <= ex_v_d;
            ex_load_q <= ex_load_d;
            ex_dst_q  <= ex_dst_d;
            mul_cnt_q <= mul_cnt_d;
            stall_q   <= stall_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_stall_ctrl
//  Description : Self-checking bench for hazard_stall_ctrl (MUL_LAT=4,
//                CNT_W=4). Inputs change on the falling edge; outputs are
//                sampled 2 ns later, well clear of the rising edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hazard_stall_ctrl;

    localparam int MUL_LAT = 4;
    localparam int CNT_W   = 4;

    logic             Clk = 1'b0;
    logic             Rst;
    logic             Valid_ID, UsesRs_ID, UsesRt_ID, RegWrite_ID;
    logic             MemRead_ID, IsMul_ID, BranchTaken_EX;
    logic [4:0]       rs_ID, rt_ID, WriteReg_ID;
    logic             PCWrite_out, IFIDWrite_out, IFIDFlush_out;
    logic             IDEXBubble_out, MulBusy_out;
    logic [CNT_W-1:0] StallCycles_out;

    hazard_stall_ctrl #(.MUL_LAT(MUL_LAT), .CNT_W(CNT_W)) dut (
        .Clk             (Clk),
        .Rst             (Rst),
        .Valid_ID        (Valid_ID),
        .rs_ID           (rs_ID),
        .rt_ID           (rt_ID),
        .UsesRs_ID       (UsesRs_ID),
        .UsesRt_ID       (UsesRt_ID),
        .RegWrite_ID     (RegWrite_ID),
        .WriteReg_ID     (WriteReg_ID),
        .MemRead_ID      (MemRead_ID),
        .IsMul_ID        (IsMul_ID),
        .BranchTaken_EX  (BranchTaken_EX),
        .PCWrite_out     (PCWrite_out),
        .IFIDWrite_out   (IFIDWrite_out),
        .IFIDFlush_out   (IFIDFlush_out),
        .IDEXBubble_out  (IDEXBubble_out),
        .MulBusy_out     (MulBusy_out),
        .StallCycles_out (StallCycles_out)
    );

    always #5 Clk = ~Clk;

    // {PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, MulBusy}
    localparam logic [4:0] NORM  = 5'b11000;
    localparam logic [4:0] LUSE  = 5'b00010;
    localparam logic [4:0] BUSY  = 5'b00001;
    localparam logic [4:0] FLUSH = 5'b11110;

    typedef struct {
        logic       v;
        logic [4:0] rs, rt;
        logic       urs, urt, rw;
        logic [4:0] wr;
        logic       mr, mul, br;
        logic [8:0] exp;
        string      nm;
    } vec_t;

    typedef struct {
        logic [8:0] o;
        string      nm;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic vec_t mk(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                                input logic urs, input logic urt, input logic rw,
                                input logic [4:0] wr, input logic mr, input logic mul,
                                input logic br, input logic [4:0] e, input int cnt,
                                input string nm);
        vec_t r;
        r.v = v; r.rs = rs; r.rt = rt; r.urs = urs; r.urt = urt; r.rw = rw;
        r.wr = wr; r.mr = mr; r.mul = mul; r.br = br;
        r.exp = {e, cnt[3:0]};
        r.nm = nm;
        return r;
    endfunction

    function automatic vec_t lw(input logic [4:0] dst, input logic [4:0] base,
                                input logic [4:0] e, input int cnt, input string nm);
        return mk(1'b1, base, 5'd0, 1'b1, 1'b0, 1'b1, dst, 1'b1, 1'b0, 1'b0, e, cnt, nm);
    endfunction

    function automatic vec_t alu(input logic [4:0] dst, input logic [4:0] rs, input logic [4:0] rt,
                                 input logic br, input logic [4:0] e, input int cnt,
                                 input string nm);
        return mk(1'b1, rs, rt, 1'b1, 1'b1, 1'b1, dst, 1'b0, 1'b0, br, e, cnt, nm);
    endfunction

    function automatic vec_t mul(input logic [4:0] dst, input logic [4:0] e, input int cnt,
                                 input string nm);
        return mk(1'b1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, dst, 1'b0, 1'b1, 1'b0, e, cnt, nm);
    endfunction

    function automatic vec_t nop(input logic [4:0] rs, input logic [4:0] e, input int cnt,
                                 input string nm);
        return mk(1'b0, rs, 5'd0, 1'b1, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, e, cnt, nm);
    endfunction

    task automatic drive(input vec_t t);
        Valid_ID       = t.v;
        rs_ID          = t.rs;
        rt_ID          = t.rt;
        UsesRs_ID      = t.urs;
        UsesRt_ID      = t.urt;
        RegWrite_ID    = t.rw;
        WriteReg_ID    = t.wr;
        MemRead_ID     = t.mr;
        IsMul_ID       = t.mul;
        BranchTaken_EX = t.br;
    endtask

    task automatic push(input logic [8:0] o, input string nm);
        exp_t e;
        e.o  = o;
        e.nm = nm;
        sb.push_back(e);
    endtask

    task automatic check_pop();
        exp_t       e;
        logic [8:0] act;
        act = {PCWrite_out, IFIDWrite_out, IFIDFlush_out, IDEXBubble_out,
               MulBusy_out, StallCycles_out};
        n_tests++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: got %b required an entry", act);
        end else begin
            e = sb.pop_front();
            if (act !== e.o) begin
                n_fail++;
                $display("FAIL %s: got %b required %b (pcw ifw fl bub busy cnt[3:0])",
                         e.nm, act, e.o);
            end
        end
    endtask

    // Drive one ID-stage record on the falling edge, check, advance one cycle.
    task automatic step(input vec_t t);
        drive(t);
        push(t.exp, t.nm);
        #2;
        check_pop();
        @(negedge Clk);
    endtask

    initial begin
        int stalls;
        int c;

        drive(nop(5'd0, NORM, 0, "init"));
        Rst = 1'b1;
        @(negedge Clk);
        push({NORM, 4'd0}, "reset_state");
        #2;
        check_pop();
        @(negedge Clk);
        Rst = 1'b0;

        // -------- main table --------
        tbl.push_back(lw (5'd5, 5'd1,          NORM,  0, "lw5_issue"));
        tbl.push_back(alu(5'd6, 5'd5, 5'd1, 0, LUSE,  0, "loaduse_rs_stall"));
        tbl.push_back(alu(5'd6, 5'd5, 5'd1, 0, NORM,  1, "loaduse_rs_release"));
        tbl.push_back(lw (5'd0, 5'd2,          NORM,  1, "lw0_issue"));
        tbl.push_back(alu(5'd7, 5'd0, 5'd0, 0, NORM,  1, "reg0_no_hazard"));
        tbl.push_back(lw (5'd5, 5'd1,          NORM,  1, "lw5_issue2"));
        tbl.push_back(mk(1'b1, 5'd5, 5'd5, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0,
                         NORM, 1, "no_uses_no_hazard"));
        tbl.push_back(lw (5'd5, 5'd1,          NORM,  1, "lw5_issue3"));
        tbl.push_back(nop(5'd5,                NORM,  1, "invalid_id_no_stall"));
        tbl.push_back(alu(5'd6, 5'd5, 5'd1, 0, NORM,  1, "invalid_id_not_advanced"));
        tbl.push_back(lw (5'd9, 5'd1,          NORM,  1, "lw9_issue"));
        tbl.push_back(alu(5'd4, 5'd0, 5'd9, 0, LUSE,  1, "loaduse_rt_stall"));
        tbl.push_back(alu(5'd4, 5'd0, 5'd9, 0, NORM,  2, "loaduse_rt_release"));
        tbl.push_back(mul(5'd10,               NORM,  2, "mul_issue"));
        tbl.push_back(alu(5'd6, 5'd10, 5'd1, 1, BUSY, 2, "mul_busy1_branch_ignored"));
        tbl.push_back(alu(5'd6, 5'd10, 5'd1, 0, BUSY, 3, "mul_busy2"));
        tbl.push_back(alu(5'd6, 5'd10, 5'd1, 0, BUSY, 4, "mul_busy3"));
        tbl.push_back(alu(5'd6, 5'd10, 5'd1, 0, NORM, 5, "mul_done"));
        tbl.push_back(lw (5'd5, 5'd1,          NORM,  5, "lw5_before_branch"));
        tbl.push_back(alu(5'd6, 5'd5, 5'd1, 1, FLUSH, 5, "branch_beats_loaduse"));
        tbl.push_back(alu(5'd6, 5'd5, 5'd1, 0, NORM,  5, "after_flush_no_stall"));
        tbl.push_back(mul(5'd11,               NORM,  5, "mul_a_issue"));
        tbl.push_back(mul(5'd12,               BUSY,  5, "b2b_busy1"));
        tbl.push_back(mul(5'd12,               BUSY,  6, "b2b_busy2"));
        tbl.push_back(mul(5'd12,               BUSY,  7, "b2b_busy3"));
        tbl.push_back(mul(5'd12,               NORM,  8, "mul_b_issue"));
        tbl.push_back(nop(5'd0,                BUSY,  8, "mul_b_busy1"));
        tbl.push_back(nop(5'd0,                BUSY,  9, "mul_b_busy2"));
        tbl.push_back(nop(5'd0,                BUSY, 10, "mul_b_busy3"));
        tbl.push_back(nop(5'd0,                NORM, 11, "mul_b_done"));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i]);
        end

        // -------- async reset in the middle of a multiply --------
        step(mul(5'd13, NORM, 11, "mul_before_reset"));
        drive(nop(5'd0, BUSY, 11, "x"));
        push({BUSY, 4'd11}, "busy_before_reset");
        #2;
        check_pop();
        #1;
        Rst = 1'b1;
        #1;
        push({NORM, 4'd0}, "async_reset_immediate");
        check_pop();
        @(negedge Clk);
        Rst = 1'b0;
        step(alu(5'd6, 5'd13, 5'd1, 0, NORM, 0, "post_reset_normal"));
        step(alu(5'd7, 5'd6,  5'd1, 0, NORM, 0, "post_reset_no_busy"));

        // -------- saturation: stream of multiplies, 21 stall cycles --------
        Rst = 1'b1;
        #1;
        Rst = 1'b0;
        stalls = 0;
        for (int k = 0; k < 28; k++) begin
            c = (stalls > 15) ? 15 : stalls;
            step(mul(5'd14, ((k % 4) == 0) ? NORM : BUSY, c, $sformatf("sat_cycle%0d", k)));
            if ((k % 4) != 0) stalls++;
        end
        step(nop(5'd0, NORM, 15, "sat_hold_F"));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
